// File: rtl/branch_pred_unit.sv
// Direct-mapped branch target buffer with saturating direction counters and perf counters.
// Latency: lookup is combinational (0 cycles); updates and flushes take effect at the next rising edge.
// Backpressure: none; the fetch stage qualifies LKP_VALID and the execute stage qualifies UPD_EN.
module branch_pred_unit #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [XLEN-1:0]   LKP_PC,
    input  logic              LKP_VALID,
    output logic              PRED_HIT,
    output logic              PRED_TAKEN,
    output logic [XLEN-1:0]   PRED_NPC,
    input  logic              UPD_EN,
    input  logic [XLEN-1:0]   UPD_PC,
    input  logic              UPD_TAKEN,
    input  logic [XLEN-1:0]   UPD_TARGET,
    input  logic              UPD_IS_JUMP,
    input  logic              UPD_MISPRED,
    input  logic              FLUSH_ALL,
    output logic [PERF_W-1:0] PERF_LOOKUPS,
    output logic [PERF_W-1:0] PERF_HITS,
    output logic [PERF_W-1:0] PERF_MISPRED
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]  CTR_ONE  = 1;
    // Weakly taken: only the MSB set, so a single not-taken flips the prediction.
    localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_ONE << (CTR_W - 1);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;
    localparam logic [PERF_W-1:0] PERF_ONE = 1;

    // Entry state: valid/ctr/is_jump are reset, tag/target are plain storage.
    logic [ENTRIES-1:0]            valid_q, valid_d;
    logic [ENTRIES-1:0]            jump_q,  jump_d;
    logic [ENTRIES-1:0][CTR_W-1:0] ctr_q,   ctr_d;
    logic [TAG_W-1:0]              tag_q    [ENTRIES];
    logic [TAG_W-1:0]              tag_d    [ENTRIES];
    logic [XLEN-1:0]               target_q [ENTRIES];
    logic [XLEN-1:0]               target_d [ENTRIES];

    logic [PERF_W-1:0] perf_lkp_q, perf_lkp_d;
    logic [PERF_W-1:0] perf_hit_q, perf_hit_d;
    logic [PERF_W-1:0] perf_mis_q, perf_mis_d;

    logic [IDX_W-1:0] lkp_idx, upd_idx;
    logic [TAG_W-1:0] lkp_tag, upd_tag;
    logic             upd_hit;

    // PC[1:0] never participate in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{LKP_PC[1:0], UPD_PC[1:0]};

    assign lkp_idx = LKP_PC[IDX_W+1:2];
    assign lkp_tag = LKP_PC[XLEN-1:IDX_W+2];
    assign upd_idx = UPD_PC[IDX_W+1:2];
    assign upd_tag = UPD_PC[XLEN-1:IDX_W+2];

    // Combinational lookup; reads the registered state so same-cycle updates are not visible.
    always_comb begin
        PRED_HIT   = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
        PRED_TAKEN = PRED_HIT && (jump_q[lkp_idx] || ctr_q[lkp_idx][CTR_W-1]);
        PRED_NPC   = PRED_TAKEN ? target_q[lkp_idx] : (LKP_PC + XLEN'(4));
    end

    // Next-state for the entry array: flush dominates, then hit-update or taken-miss allocate.
    always_comb begin
        valid_d  = valid_q;
        jump_d   = jump_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (FLUSH_ALL) begin
            valid_d = '0;
        end else if (UPD_EN) begin
            if (upd_hit) begin
                jump_d[upd_idx] = UPD_IS_JUMP;
                if (UPD_TAKEN) begin
                    target_d[upd_idx] = UPD_TARGET;
                end
                if (UPD_IS_JUMP) begin
                    ctr_d[upd_idx] = CTR_MAX;
                end else if (UPD_TAKEN) begin
                    if (ctr_q[upd_idx] != CTR_MAX) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_ONE;
                    end
                end else begin
                    if (ctr_q[upd_idx] != '0) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_ONE;
                    end
                end
            end else if (UPD_TAKEN) begin
                // Not-taken misses never allocate; they would only evict useful entries.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = UPD_TARGET;
                jump_d[upd_idx]   = UPD_IS_JUMP;
                ctr_d[upd_idx]    = UPD_IS_JUMP ? CTR_MAX : CTR_WEAK;
            end
        end
    end

    // Saturating performance counters; flush leaves them alone.
    always_comb begin
        perf_lkp_d = perf_lkp_q;
        perf_hit_d = perf_hit_q;
        perf_mis_d = perf_mis_q;
        if (LKP_VALID && (perf_lkp_q != PERF_MAX)) begin
            perf_lkp_d = perf_lkp_q + PERF_ONE;
        end
        if (LKP_VALID && PRED_HIT && (perf_hit_q != PERF_MAX)) begin
            perf_hit_d = perf_hit_q + PERF_ONE;
        end
        if (UPD_EN && UPD_MISPRED && (perf_mis_q != PERF_MAX)) begin
            perf_mis_d = perf_mis_q + PERF_ONE;
        end
    end

    // Reset-bearing state: entry control bits and perf counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q    <= '0;
            jump_q     <= '0;
            ctr_q      <= '0;
            perf_lkp_q <= '0;
            perf_hit_q <= '0;
            perf_mis_q <= '0;
        end else begin
            valid_q    <= valid_d;
            jump_q     <= jump_d;
            ctr_q      <= ctr_d;
            perf_lkp_q <= perf_lkp_d;
            perf_hit_q <= perf_hit_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    // Tag/target storage is only meaningful behind a valid bit, so it carries no reset.
    always_ff @(posedge CLK) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign PERF_LOOKUPS = perf_lkp_q;
    assign PERF_HITS    = perf_hit_q;
    assign PERF_MISPRED = perf_mis_q;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed bench for branch_pred_unit (XLEN=32, ENTRIES=16, CTR_W=2, PERF_W=4).
// Inputs change 1ns after a rising edge; combinational outputs are sampled 1ns after that.
// Each scenario task checks its own expectations inline.
module tb_branch_pred_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] LKP_PC;
    logic        LKP_VALID;
    logic        PRED_HIT;
    logic        PRED_TAKEN;
    logic [31:0] PRED_NPC;
    logic        UPD_EN;
    logic [31:0] UPD_PC;
    logic        UPD_TAKEN;
    logic [31:0] UPD_TARGET;
    logic        UPD_IS_JUMP;
    logic        UPD_MISPRED;
    logic        FLUSH_ALL;
    logic [3:0]  PERF_LOOKUPS;
    logic [3:0]  PERF_HITS;
    logic [3:0]  PERF_MISPRED;

    int checks = 0;
    int errors = 0;

    branch_pred_unit #(.XLEN(32), .ENTRIES(16), .CTR_W(2), .PERF_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .LKP_PC(LKP_PC), .LKP_VALID(LKP_VALID),
        .PRED_HIT(PRED_HIT), .PRED_TAKEN(PRED_TAKEN), .PRED_NPC(PRED_NPC),
        .UPD_EN(UPD_EN), .UPD_PC(UPD_PC), .UPD_TAKEN(UPD_TAKEN),
        .UPD_TARGET(UPD_TARGET), .UPD_IS_JUMP(UPD_IS_JUMP), .UPD_MISPRED(UPD_MISPRED),
        .FLUSH_ALL(FLUSH_ALL),
        .PERF_LOOKUPS(PERF_LOOKUPS), .PERF_HITS(PERF_HITS), .PERF_MISPRED(PERF_MISPRED)
    );

    always #5 CLK = ~CLK;

    // Drive a lookup PC and let the combinational path settle.
    task automatic look(input logic [31:0] pc);
        LKP_PC = pc;
        #1;
    endtask

    // One-cycle update pulse; returns 1ns after the edge that applied it.
    task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic jmp, input logic mis);
        UPD_EN = 1'b1; UPD_PC = pc; UPD_TAKEN = tk; UPD_TARGET = tgt;
        UPD_IS_JUMP = jmp; UPD_MISPRED = mis;
        @(posedge CLK); #1;
        UPD_EN = 1'b0; UPD_MISPRED = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; LKP_PC = 32'h100; LKP_VALID = 1'b0; UPD_EN = 1'b0; UPD_PC = '0;
        UPD_TAKEN = 1'b0; UPD_TARGET = '0; UPD_IS_JUMP = 1'b0; UPD_MISPRED = 1'b0; FLUSH_ALL = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        look(32'h100);
        checks++; if (PRED_HIT !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0h want 0", PRED_HIT); end
        checks++; if (PRED_TAKEN !== 1'b0) begin errors++; $display("FAIL reset_taken: got %0h want 0", PRED_TAKEN); end
        checks++; if (PRED_NPC !== 32'h104) begin errors++; $display("FAIL reset_npc: got %08h want 00000104", PRED_NPC); end
        checks++; if ({PERF_LOOKUPS, PERF_HITS, PERF_MISPRED} !== 12'h000) begin errors++;
            $display("FAIL reset_perf: got %0h/%0h/%0h want 0/0/0", PERF_LOOKUPS, PERF_HITS, PERF_MISPRED); end
        look(32'hFFFF_FFFC);
        checks++; if (PRED_NPC !== 32'h0) begin errors++; $display("FAIL npc_wrap: got %08h want 00000000", PRED_NPC); end
    endtask

    task automatic test_alloc();
        do_upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
        look(32'h100);
        checks++; if ({PRED_HIT, PRED_TAKEN} !== 2'b11) begin errors++; $display("FAIL alloc_hit_taken: got %b want 11", {PRED_HIT, PRED_TAKEN}); end
        checks++; if (PRED_NPC !== 32'h80) begin errors++; $display("FAIL alloc_npc: got %08h want 00000080", PRED_NPC); end
        look(32'h104);
        checks++; if (PRED_HIT !== 1'b0) begin errors++; $display("FAIL alloc_other_idx: got %0h want 0", PRED_HIT); end
    endtask

    task automatic test_counter();
        // 10 -> 01 -> 00 -> 00 (floor) -> 01
        do_upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        look(32'h100);
        checks++; if ({PRED_HIT, PRED_TAKEN} !== 2'b10 || PRED_NPC !== 32'h104) begin errors++;
            $display("FAIL ctr_01: got hit/tk %b npc %08h want 10 00000104", {PRED_HIT, PRED_TAKEN}, PRED_NPC); end
        do_upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        look(32'h100);
        checks++; if ({PRED_HIT, PRED_TAKEN} !== 2'b10 || PRED_NPC !== 32'h104) begin errors++;
            $display("FAIL ctr_00: got hit/tk %b npc %08h want 10 00000104", {PRED_HIT, PRED_TAKEN}, PRED_NPC); end
        do_upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        do_upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
        look(32'h100);
        checks++; if ({PRED_HIT, PRED_TAKEN} !== 2'b10) begin errors++;
            $display("FAIL ctr_floor_then_01: got hit/tk %b want 10", {PRED_HIT, PRED_TAKEN}); end
        // 01 -> 10 (taken again)
        do_upd(32'h100, 1'b1, 32'h88, 1'b0, 1'b0);
        look(32'h100);
        checks++; if (PRED_TAKEN !== 1'b1 || PRED_NPC !== 32'h88) begin errors++;
            $display("FAIL ctr_10_newtgt: got tk %0h npc %08h want 1 00000088", PRED_TAKEN, PRED_NPC); end
        // 10 -> 11 -> 11 (ceiling) -> 10: must still be taken
        do_upd(32'h100, 1'b1, 32'h88, 1'b0, 1'b0);
        do_upd(32'h100, 1'b1, 32'h88, 1'b0, 1'b0);
        do_upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        look(32'h100);
        checks++; if (PRED_TAKEN !== 1'b1 || PRED_NPC !== 32'h88) begin errors++;
            $display("FAIL ctr_ceiling: got tk %0h npc %08h want 1 00000088", PRED_TAKEN, PRED_NPC); end
    endtask

    task automatic test_alias_jump();
        do_upd(32'h140, 1'b1, 32'h200, 1'b0, 1'b0);
        look(32'h100);
        checks++; if (PRED_HIT !== 1'b0 || PRED_NPC !== 32'h104) begin errors++;
            $display("FAIL alias_evict: got hit %0h npc %08h want 0 00000104", PRED_HIT, PRED_NPC); end
        look(32'h140);
        checks++; if (PRED_HIT !== 1'b1 || PRED_NPC !== 32'h200) begin errors++;
            $display("FAIL alias_new: got hit %0h npc %08h want 1 00000200", PRED_HIT, PRED_NPC); end
        do_upd(32'h140, 1'b1, 32'h300, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) do_upd(32'h140, 1'b0, 32'h0, 1'b1, 1'b0);
        look(32'h140);
        checks++; if (PRED_TAKEN !== 1'b1 || PRED_NPC !== 32'h300) begin errors++;
            $display("FAIL jump_always_taken: got tk %0h npc %08h want 1 00000300", PRED_TAKEN, PRED_NPC); end
    endtask

    task automatic test_same_cycle();
        // Update and lookup on index 0 together: lookup still sees the 0x140 entry.
        UPD_EN = 1'b1; UPD_PC = 32'h100; UPD_TAKEN = 1'b1; UPD_TARGET = 32'h500; UPD_IS_JUMP = 1'b0;
        look(32'h100);
        checks++; if (PRED_HIT !== 1'b0 || PRED_NPC !== 32'h104) begin errors++;
            $display("FAIL same_cycle_old: got hit %0h npc %08h want 0 00000104", PRED_HIT, PRED_NPC); end
        @(posedge CLK); #1;
        UPD_EN = 1'b0;
        look(32'h100);
        checks++; if (PRED_HIT !== 1'b1 || PRED_NPC !== 32'h500) begin errors++;
            $display("FAIL same_cycle_next: got hit %0h npc %08h want 1 00000500", PRED_HIT, PRED_NPC); end
        // Flush and update together: flush wins, nothing is allocated.
        FLUSH_ALL = 1'b1;
        do_upd(32'h200, 1'b1, 32'h600, 1'b0, 1'b0);
        FLUSH_ALL = 1'b0;
        look(32'h200);
        checks++; if (PRED_HIT !== 1'b0 || PRED_NPC !== 32'h204) begin errors++;
            $display("FAIL flush_wins: got hit %0h npc %08h want 0 00000204", PRED_HIT, PRED_NPC); end
        look(32'h100);
        checks++; if (PRED_HIT !== 1'b0) begin errors++; $display("FAIL flush_clears: got hit %0h want 0", PRED_HIT); end
    endtask

    task automatic test_perf();
        do_upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b1);
        checks++; if (PERF_MISPRED !== 4'd1) begin errors++; $display("FAIL perf_mis_one: got %0d want 1", PERF_MISPRED); end
        LKP_VALID = 1'b1; LKP_PC = 32'h100;
        repeat (3) @(posedge CLK);
        #1; LKP_PC = 32'h104;
        repeat (2) @(posedge CLK);
        #1; LKP_VALID = 1'b0;
        checks++; if (PERF_LOOKUPS !== 4'd5 || PERF_HITS !== 4'd3) begin errors++;
            $display("FAIL perf_lkp_hit: got %0d/%0d want 5/3", PERF_LOOKUPS, PERF_HITS); end
        // 20 more mispredicts (not-taken misses, no allocation) with misses being looked up.
        LKP_VALID = 1'b1; UPD_EN = 1'b1; UPD_PC = 32'h104; UPD_TAKEN = 1'b0; UPD_IS_JUMP = 1'b0; UPD_MISPRED = 1'b1;
        repeat (20) @(posedge CLK);
        #1; LKP_VALID = 1'b0; UPD_EN = 1'b0; UPD_MISPRED = 1'b0;
        checks++; if (PERF_MISPRED !== 4'd15) begin errors++; $display("FAIL perf_mis_sat: got %0d want 15", PERF_MISPRED); end
        checks++; if (PERF_LOOKUPS !== 4'd15 || PERF_HITS !== 4'd3) begin errors++;
            $display("FAIL perf_lkp_sat: got %0d/%0d want 15/3", PERF_LOOKUPS, PERF_HITS); end
        look(32'h104);
        checks++; if (PRED_HIT !== 1'b0) begin errors++; $display("FAIL nt_miss_no_alloc: got hit %0h want 0", PRED_HIT); end
        FLUSH_ALL = 1'b1;
        @(posedge CLK); #1;
        FLUSH_ALL = 1'b0;
        checks++; if (PERF_MISPRED !== 4'd15 || PERF_LOOKUPS !== 4'd15) begin errors++;
            $display("FAIL perf_survives_flush: got %0d/%0d want 15/15", PERF_MISPRED, PERF_LOOKUPS); end
    endtask

    task automatic test_reset_mid();
        do_upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
        // Start an update to index 1, then assert reset between edges.
        UPD_EN = 1'b1; UPD_PC = 32'h104; UPD_TAKEN = 1'b1; UPD_TARGET = 32'h900; UPD_IS_JUMP = 1'b0; UPD_MISPRED = 1'b1;
        look(32'h100);
        checks++; if (PRED_HIT !== 1'b1) begin errors++; $display("FAIL pre_reset_hit: got %0h want 1", PRED_HIT); end
        #1; RST = 1'b1; #1;
        checks++; if (PRED_HIT !== 1'b0 || PRED_TAKEN !== 1'b0 || PRED_NPC !== 32'h104) begin errors++;
            $display("FAIL async_reset_out: got hit %0h tk %0h npc %08h want 0 0 00000104", PRED_HIT, PRED_TAKEN, PRED_NPC); end
        checks++; if ({PERF_LOOKUPS, PERF_HITS, PERF_MISPRED} !== 12'h000) begin errors++;
            $display("FAIL async_reset_perf: got %0d/%0d/%0d want 0/0/0", PERF_LOOKUPS, PERF_HITS, PERF_MISPRED); end
        @(posedge CLK); #1;
        RST = 1'b0; UPD_EN = 1'b0; UPD_MISPRED = 1'b0;
        look(32'h104);
        checks++; if (PRED_HIT !== 1'b0 || PRED_NPC !== 32'h108) begin errors++;
            $display("FAIL update_lost: got hit %0h npc %08h want 0 00000108", PRED_HIT, PRED_NPC); end
        checks++; if (PERF_MISPRED !== 4'd0) begin errors++; $display("FAIL mis_lost: got %0d want 0", PERF_MISPRED); end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_alias_jump();
        test_same_cycle();
        test_perf();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_pred_unit.md
Name: branch_pred_unit

Overview:
Parametrised direct-mapped branch target buffer with saturating-counter direction prediction. It extends the fetch-stage PC mux, which today selects only next-PC or the JAL target, with speculative next-PC selection for branches, JAL and JALR. Lookup is combinational from the fetch-stage PC. Update is sequential, driven from the execute stage once branch outcome and target resolve. Saturating performance counters are included for lookups, hits and mispredicts.

Parameters:
XLEN, 32, address/target width in bits
ENTRIES, 16, BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES)
CTR_W, 2, direction counter width, 1..4
PERF_W, 32, performance counter width, ≥1

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
LKP_PC  in  XLEN  fetch-stage PC to look up
LKP_VALID  in  1  lookup is real (fetch not stalled); qualifies perf counting only
PRED_HIT  out  1  valid entry with matching tag
PRED_TAKEN  out  1  predicted taken
PRED_NPC  out  XLEN  predicted next PC
UPD_EN  in  1  execute-stage resolved control-flow instruction
UPD_PC  in  XLEN  PC of resolved instruction
UPD_TAKEN  in  1  actual outcome
UPD_TARGET  in  XLEN  actual target
UPD_IS_JUMP  in  1  JAL/JALR (unconditional)
UPD_MISPRED  in  1  prediction was wrong; perf counting only
FLUSH_ALL  in  1  synchronous invalidate of all entries
PERF_LOOKUPS  out  PERF_W  count of LKP_VALID cycles
PERF_HITS  out  PERF_W  count of LKP_VALID && PRED_HIT cycles
PERF_MISPRED  out  PERF_W  count of UPD_EN && UPD_MISPRED cycles

Behaviour:
- Index = PC[IDX_W+1:2]. Tag = PC[XLEN-1:IDX_W+2]. PC[1:0] are ignored.
- Each entry holds: valid, tag, target[XLEN], ctr[CTR_W], is_jump.
- Lookup is purely combinational, with zero latency.
  - PRED_HIT = valid && tag match.
  - PRED_TAKEN = PRED_HIT && (is_jump || ctr[CTR_W-1]).
  - PRED_NPC = PRED_TAKEN ? target : LKP_PC+4. The add wraps modulo 2^XLEN.
- Update happens at the clock edge when UPD_EN=1, on entry idx(UPD_PC).
  - Hit (valid, tag match):
    - Conditional branch: ctr increments if UPD_TAKEN, decrements otherwise, saturating at 0 and 2^CTR_W-1.
    - If UPD_TAKEN, target <= UPD_TARGET.
    - is_jump <= UPD_IS_JUMP.
  - Miss with UPD_TAKEN=1: allocate/replace the entry.
    - valid=1, tag and target written.
    - is_jump = UPD_IS_JUMP.
    - ctr = weakly taken, i.e. MSB=1 and all other bits 0 (2'b10 for CTR_W=2; 1'b1 for CTR_W=1).
  - Miss with UPD_TAKEN=0: no change (no allocation for not-taken).
  - Jump entries: ctr is set to all-ones on every update; they are always predicted taken.
- A lookup and update to the same index in the same cycle: the lookup returns the pre-update contents. The new contents are visible from the next cycle.
- FLUSH_ALL clears every valid bit at the clock edge.
  - If FLUSH_ALL and UPD_EN are both high, the flush wins and the update is dropped.
  - Counters and targets need not be cleared by FLUSH_ALL.
- Perf counters increment by 1 per qualifying cycle and saturate at 2^PERF_W-1 (no wrap). FLUSH_ALL does not clear them.
- Reset (asynchronous, effective immediately, including mid-update):
  - All valid=0, all ctr=0, all is_jump=0.
  - All perf counters = 0.
  - Target/tag storage does not require reset.
- Resulting outputs during and after reset: PRED_HIT=0, PRED_TAKEN=0, PRED_NPC=LKP_PC+4, all PERF_* = 0.
- No internal stall or handshake: the caller gates UPD_EN and LKP_VALID.

Test Plan:
(XLEN=32, ENTRIES=16, CTR_W=2.)
1. Reset, then lookup 0x100 -> PRED_HIT=0, PRED_TAKEN=0, PRED_NPC=0x104. A lookup of 0xFFFFFFFC -> PRED_NPC=0x00000000 (wrap).
2. UPD_EN, PC=0x100, taken, target 0x80, branch; lookup 0x100 next cycle -> HIT=1, TAKEN=1, NPC=0x80 (ctr=10).
3. Two not-taken updates to 0x100 -> ctr 01 then 00; lookup gives TAKEN=0, NPC=0x104, HIT=1. A third not-taken keeps ctr=00. One taken -> ctr=01, still not taken.
4. Alias: update 0x140 (same index 0) taken to 0x200 -> lookup 0x100 HIT=0; lookup 0x140 NPC=0x200. Then a JAL update at 0x140 followed by 3 not-taken-branch-style updates -> still TAKEN=1.
5. Same-cycle checks:
   - Update 0x100 and lookup 0x100 in one cycle -> the lookup sees the old entry.
   - FLUSH_ALL with UPD_EN in the same cycle -> the entry stays invalid next cycle.
6. Assert RST asynchronously mid-update (between edges) -> outputs go immediately to reset values and the update is lost. With PERF_W=4, 20 mispredict updates -> PERF_MISPRED=15 (saturated).
